// File: rtl/bProcess_pkg.sv
// Shared definitions for the branch resolve queue and the branch-process stage that
// decodes its back-end packets: packet layout, entry layout and control states.
package bProcess_pkg;

    localparam int PKT_W    = 42;
    localparam int MISP_BIT = 41;
    localparam int CNT_HI   = 40;
    localparam int CNT_LO   = 38;
    localparam int ERR_HI   = 37;
    localparam int ERR_LO   = 35;
    localparam int PC_HI    = 31;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SEND  = 2'd1,
        FLUSH = 2'd2
    } brq_state_e;

    typedef struct packed {
        logic        mispredict;
        logic [2:0]  counter;
        logic [2:0]  err_idx;
        logic [2:0]  rsvd;
        logic [31:0] correct_pc;
    } brq_pkt_t;

    typedef struct packed {
        logic        valid;
        logic        resolved;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic [31:0] fallthrough;
        logic        act_taken;
        logic [31:0] act_target;
    } brq_entry_t;

endpackage

// File: rtl/b_resolve_entry_ram.sv
// Entry storage for the resolve queue: one write port for enqueue, one for resolution,
// per-entry retire clear, whole-queue squash, and an asynchronous read of the head entry.
module b_resolve_entry_ram
    import bProcess_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enq_we,
    input  logic [2:0]  enq_idx,
    input  logic        enq_taken,
    input  logic [31:0] enq_target,
    input  logic [31:0] enq_fallthrough,
    input  logic        res_we,
    input  logic [2:0]  res_idx,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic        ret_we,
    input  logic        flush,
    input  logic [2:0]  head_idx,
    output brq_entry_t  head_entry
);

    brq_entry_t entries_q [DEPTH];
    brq_entry_t entries_d [DEPTH];

    // Later writes win: a squash discards anything enqueued or resolved in the same cycle.
    always_comb begin
        entries_d = entries_q;
        if (enq_we) begin
            entries_d[enq_idx]             = '0;
            entries_d[enq_idx].valid       = 1'b1;
            entries_d[enq_idx].pred_taken  = enq_taken;
            entries_d[enq_idx].pred_target = enq_target;
            entries_d[enq_idx].fallthrough = enq_fallthrough;
        end
        if (res_we && entries_q[res_idx].valid && !entries_q[res_idx].resolved) begin
            entries_d[res_idx].resolved   = 1'b1;
            entries_d[res_idx].act_taken  = res_taken;
            entries_d[res_idx].act_target = res_target;
        end
        if (ret_we) begin
            entries_d[head_idx].valid    = 1'b0;
            entries_d[head_idx].resolved = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid    = 1'b0;
                entries_d[i].resolved = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

    assign head_entry = entries_q[head_idx];

endmodule

// File: rtl/b_resolve_queue.sv
// In-order tracker of predicted branches: enqueues predictions, takes out-of-order
// resolutions by tag, retires in program order and emits commit / mispredict packets.
module b_resolve_queue
    import bProcess_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int GROUP = 4,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic             enq_taken,
    input  logic [PC_W-1:0]  enq_target,
    input  logic [PC_W-1:0]  enq_fallthrough,
    output logic [2:0]       enq_tag,
    input  logic             res_valid,
    input  logic [2:0]       res_tag,
    input  logic             res_taken,
    input  logic [PC_W-1:0]  res_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PKT_W-1:0] out_data,
    output logic [3:0]       occupancy
);

    localparam logic [2:0] PTR_MASK = 3'(DEPTH - 1);

    brq_state_e       state_q, state_d;
    logic [2:0]       head_q, head_d;
    logic [2:0]       tail_q, tail_d;
    logic [3:0]       count_q, count_d;
    logic [2:0]       acc_q, acc_d;
    logic [PKT_W-1:0] pkt_q, pkt_d;

    logic       enq_fire;
    logic       res_we;
    logic       retire;
    logic       squash;
    logic       head_misp;
    brq_entry_t head_entry;

    function automatic logic [2:0] ptr_inc(input logic [2:0] p);
        return (p + 3'd1) & PTR_MASK;
    endfunction

    b_resolve_entry_ram #(.DEPTH(DEPTH)) u_ram (
        .clk             (clk),
        .rst             (rst),
        .enq_we          (enq_fire),
        .enq_idx         (tail_q),
        .enq_taken       (enq_taken),
        .enq_target      (enq_target),
        .enq_fallthrough (enq_fallthrough),
        .res_we          (res_we),
        .res_idx         (res_tag),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .ret_we          (retire),
        .flush           (squash),
        .head_idx        (head_q),
        .head_entry      (head_entry)
    );

    assign enq_fire  = enq_valid & enq_ready;
    assign res_we    = res_valid & (state_q != FLUSH);
    assign head_misp = (head_entry.act_taken != head_entry.pred_taken) ||
                       (head_entry.act_taken && (head_entry.act_target != head_entry.pred_target));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            acc_q   <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            pkt_q   <= pkt_d;
        end
    end

    // A full commit group is flushed out before another entry may retire.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        acc_d   = acc_q;
        pkt_d   = pkt_q;
        retire  = 1'b0;
        squash  = 1'b0;
        unique case (state_q)
            ACCUM: begin
                if (acc_q == 3'(GROUP)) begin
                    pkt_d                 = '0;
                    pkt_d[CNT_HI:CNT_LO]  = acc_q;
                    acc_d                 = '0;
                    state_d               = SEND;
                end else if (head_entry.valid && head_entry.resolved) begin
                    if (head_misp) begin
                        pkt_d                = '0;
                        pkt_d[MISP_BIT]      = 1'b1;
                        pkt_d[CNT_HI:CNT_LO] = acc_q;
                        pkt_d[ERR_HI:ERR_LO] = acc_q;
                        pkt_d[PC_HI:0]       = head_entry.act_taken ? head_entry.act_target
                                                                    : head_entry.fallthrough;
                        acc_d                = '0;
                        squash               = 1'b1;
                        state_d              = FLUSH;
                    end else begin
                        retire = 1'b1;
                        acc_d  = acc_q + 3'd1;
                    end
                end else if ((acc_q != 3'd0) && (count_q == 4'd0)) begin
                    pkt_d                = '0;
                    pkt_d[CNT_HI:CNT_LO] = acc_q;
                    acc_d                = '0;
                    state_d              = SEND;
                end
            end
            SEND, FLUSH: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
        if (enq_fire) begin
            tail_d = ptr_inc(tail_q);
        end
        if (retire) begin
            head_d = ptr_inc(head_q);
        end
        count_d = count_q + 4'(enq_fire) - 4'(retire);
        if (squash) begin
            tail_d  = head_q;
            count_d = '0;
        end
    end

    always_comb begin
        out_valid = (state_q != ACCUM);
        enq_ready = (count_q < 4'(DEPTH)) && (state_q != FLUSH);
    end

    assign out_data  = pkt_q;
    assign enq_tag   = tail_q;
    assign occupancy = count_q;

endmodule

// File: tb/tb_b_resolve_queue.sv
// Bench for b_resolve_queue: directed scenarios plus random traffic, every cycle checked
// against a program-order queue model of retirement, grouping and flush behaviour.
module tb_b_resolve_queue;

    localparam int DEPTH = 8;
    localparam int GROUP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid;
    logic        enq_ready;
    logic        enq_taken;
    logic [31:0] enq_target;
    logic [31:0] enq_fallthrough;
    logic [2:0]  enq_tag;
    logic        res_valid;
    logic [2:0]  res_tag;
    logic        res_taken;
    logic [31:0] res_target;
    logic        out_valid;
    logic        out_ready;
    logic [41:0] out_data;
    logic [3:0]  occupancy;

    b_resolve_queue #(.DEPTH(DEPTH), .GROUP(GROUP), .PC_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .enq_valid       (enq_valid),
        .enq_ready       (enq_ready),
        .enq_taken       (enq_taken),
        .enq_target      (enq_target),
        .enq_fallthrough (enq_fallthrough),
        .enq_tag         (enq_tag),
        .res_valid       (res_valid),
        .res_tag         (res_tag),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pt;
        logic [31:0] ptgt;
        logic [31:0] fall;
        bit          res;
        logic        at;
        logic [31:0] atgt;
    } ment_t;

    // Model: live branches in program order, oldest first; tag of entry k = (m_head + k) mod DEPTH.
    ment_t       mq[$];
    int          m_head;
    int          m_acc;
    bit          m_pend;
    bit          m_flush;
    logic [41:0] m_pkt;

    int vec_count = 0;
    int err_count = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_head  = 0;
        m_acc   = 0;
        m_pend  = 1'b0;
        m_flush = 1'b0;
        m_pkt   = '0;
    endtask

    task automatic checkModel();
        checkOutput("out_valid", 64'(out_valid), 64'(m_pend));
        if (m_pend) checkOutput("out_data", 64'(out_data), 64'(m_pkt));
        checkOutput("occupancy", 64'(occupancy), 64'(mq.size()));
        checkOutput("enq_ready", 64'(enq_ready), 64'((mq.size() < DEPTH) && !(m_pend && m_flush)));
        checkOutput("enq_tag", 64'(enq_tag), 64'((m_head + mq.size()) % DEPTH));
    endtask

    task automatic modelStep(input logic r, input logic ev, input logic et, input logic [31:0] etgt,
                             input logic [31:0] efall, input logic rv, input logic [2:0] rtag,
                             input logic rtk, input logic [31:0] rtgt, input logic ordy);
        bit    can_enq;
        bit    in_flush;
        bit    do_ret;
        bit    do_sq;
        bit    misp;
        int    idx;
        ment_t ne;
        if (r) begin
            modelReset();
            return;
        end
        can_enq  = (mq.size() < DEPTH) && !(m_pend && m_flush);
        in_flush = m_pend && m_flush;
        do_ret   = 1'b0;
        do_sq    = 1'b0;
        if (m_pend) begin
            if (ordy) m_pend = 1'b0;
        end else if (m_acc == GROUP) begin
            m_pkt  = {1'b0, 3'(m_acc), 3'd0, 3'd0, 32'h0};
            m_acc  = 0;
            m_pend = 1'b1; m_flush = 1'b0;
        end else if (mq.size() > 0 && mq[0].res) begin
            misp = (mq[0].at != mq[0].pt) || (mq[0].at && (mq[0].atgt != mq[0].ptgt));
            if (misp) begin
                m_pkt  = {1'b1, 3'(m_acc), 3'(m_acc), 3'd0, mq[0].at ? mq[0].atgt : mq[0].fall};
                m_acc  = 0;
                m_pend = 1'b1; m_flush = 1'b1;
                do_sq  = 1'b1;
            end else begin
                do_ret = 1'b1;
                m_acc++;
            end
        end else if (m_acc > 0 && mq.size() == 0) begin
            m_pkt  = {1'b0, 3'(m_acc), 3'd0, 3'd0, 32'h0};
            m_acc  = 0;
            m_pend = 1'b1; m_flush = 1'b0;
        end
        if (rv && !in_flush) begin
            idx = (int'(rtag) - m_head + DEPTH) % DEPTH;
            if (idx < mq.size() && !mq[idx].res) begin
                mq[idx].res  = 1'b1;
                mq[idx].at   = rtk;
                mq[idx].atgt = rtgt;
            end
        end
        if (ev && can_enq) begin
            ne.pt = et; ne.ptgt = etgt; ne.fall = efall;
            ne.res = 1'b0; ne.at = 1'b0; ne.atgt = '0;
            mq.push_back(ne);
        end
        if (do_ret) begin
            void'(mq.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
        if (do_sq) mq.delete();
    endtask

    task automatic applyStimulus(input logic r, input logic ev, input logic et, input logic [31:0] etgt,
                                 input logic [31:0] efall, input logic rv, input logic [2:0] rtag,
                                 input logic rtk, input logic [31:0] rtgt, input logic ordy);
        rst = r; enq_valid = ev; enq_taken = et; enq_target = etgt; enq_fallthrough = efall;
        res_valid = rv; res_tag = rtag; res_taken = rtk; res_target = rtgt; out_ready = ordy;
        checkModel();
        modelStep(r, ev, et, etgt, efall, rv, rtag, rtk, rtgt, ordy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 3'd0, 1'b0, '0, ordy);
    endtask

    task automatic enq(input logic t, input logic [31:0] tgt, input logic [31:0] fall);
        applyStimulus(1'b0, 1'b1, t, tgt, fall, 1'b0, 3'd0, 1'b0, '0, 1'b0);
    endtask

    task automatic res(input logic [2:0] tag, input logic tk, input logic [31:0] tgt);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, tag, tk, tgt, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 3'd0, 1'b0, '0, 1'b0);
    endtask

    task automatic waitPacket(input string tag);
        for (int i = 0; i < 30 && !out_valid; i++) idle(1'b0);
        checkOutput(tag, 64'(out_valid), 64'd1);
    endtask

    logic [41:0] exp_pkt;

    initial begin
        rst = 1'b1; enq_valid = 1'b0; enq_taken = 1'b0; enq_target = '0; enq_fallthrough = '0;
        res_valid = 1'b0; res_tag = '0; res_taken = 1'b0; res_target = '0; out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        modelReset();
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
        checkOutput("rst_enq_ready", 64'(enq_ready), 64'd1);
        checkOutput("rst_enq_tag", 64'(enq_tag), 64'd0);

        // Reverse-order resolution still retires in order and yields one commit packet.
        doReset();
        for (int i = 0; i < 4; i++) enq(1'b0, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16));
        for (int i = 3; i >= 0; i--) res(3'(i), 1'b0, '0);
        waitPacket("t1_pkt_wait");
        exp_pkt = {1'b0, 3'd4, 3'd0, 3'd0, 32'h0};
        checkOutput("t1_pkt", 64'(out_data), 64'(exp_pkt));
        idle(1'b1);
        checkOutput("t1_drop", 64'(out_valid), 64'd0);

        // Direction mispredict on tag1 after one correct retire.
        doReset();
        enq(1'b0, 32'h40, 32'h44);
        enq(1'b1, 32'h100, 32'h208);
        enq(1'b0, 32'h300, 32'h304);
        res(3'd0, 1'b0, '0);
        res(3'd1, 1'b0, '0);
        res(3'd2, 1'b0, '0);
        exp_pkt = {1'b1, 3'd1, 3'd1, 3'd0, 32'h208};
        checkOutput("t2_valid", 64'(out_valid), 64'd1);
        checkOutput("t2_pkt", 64'(out_data), 64'(exp_pkt));
        checkOutput("t2_occ", 64'(occupancy), 64'd0);
        checkOutput("t2_ready", 64'(enq_ready), 64'd0);
        enq(1'b0, 32'h500, 32'h504);
        enq(1'b0, 32'h510, 32'h514);
        checkOutput("t2_occ_hold", 64'(occupancy), 64'd0);
        idle(1'b1);
        checkOutput("t2_ready_after", 64'(enq_ready), 64'd1);

        // Full queue, then one retire frees a slot and the tail wraps.
        doReset();
        for (int i = 0; i < 8; i++) enq(1'b0, 32'(i * 16), 32'(i * 16 + 4));
        checkOutput("t3_ready_full", 64'(enq_ready), 64'd0);
        checkOutput("t3_occ_full", 64'(occupancy), 64'd8);
        res(3'd0, 1'b0, '0);
        idle(1'b0);
        checkOutput("t3_ready_free", 64'(enq_ready), 64'd1);
        checkOutput("t3_occ_free", 64'(occupancy), 64'd7);
        checkOutput("t3_wrap_tag", 64'(enq_tag), 64'd0);
        enq(1'b1, 32'h500, 32'h504);
        checkOutput("t3_occ_refill", 64'(occupancy), 64'd8);

        // Back-pressure in SEND: packet held while enq/resolve continue, no retire.
        doReset();
        for (int i = 0; i < 4; i++) enq(1'b0, 32'h600 + 32'(i * 16), 32'h700 + 32'(i * 16));
        for (int i = 0; i < 4; i++) res(3'(i), 1'b0, '0);
        waitPacket("t4_pkt_wait");
        exp_pkt = {1'b0, 3'd4, 3'd0, 3'd0, 32'h0};
        for (int i = 0; i < 10; i++) begin
            checkOutput("t4_stable", 64'(out_data), 64'(exp_pkt));
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h800 + 32'(i * 16), 32'h900 + 32'(i * 16),
                          1'b1, 3'((3 + i) % 8), 1'b0, '0, 1'b0);
        end
        checkOutput("t4_occ_hold", 64'(occupancy), 64'd8);
        idle(1'b1);
        idle(1'b0);
        checkOutput("t4_resume", 64'(occupancy), 64'd7);

        // Reset while a mispredict packet is pending.
        doReset();
        enq(1'b1, 32'h80, 32'h84);
        res(3'd0, 1'b0, '0);
        idle(1'b0);
        checkOutput("t5_flush", 64'(out_valid), 64'd1);
        doReset();
        checkOutput("t5_valid", 64'(out_valid), 64'd0);
        checkOutput("t5_occ", 64'(occupancy), 64'd0);
        checkOutput("t5_ready", 64'(enq_ready), 64'd1);

        // Invalid tag ignored; second resolve of the same tag ignored.
        doReset();
        enq(1'b0, 32'h40, 32'h50);
        res(3'd5, 1'b1, 32'h99);
        res(3'd0, 1'b1, 32'h77);
        res(3'd0, 1'b0, 32'h0);
        exp_pkt = {1'b1, 3'd0, 3'd0, 3'd0, 32'h77};
        checkOutput("t6_valid", 64'(out_valid), 64'd1);
        checkOutput("t6_pkt", 64'(out_data), 64'(exp_pkt));
        idle(1'b1);

        // Random traffic against the model.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            logic        r, ev, et, rv, rtk, ordy;
            logic [31:0] etgt, efall, rtgt;
            logic [2:0]  rtag;
            int          k;
            r     = ($urandom_range(0, 999) == 0);
            ev    = ($urandom_range(0, 99) < 60);
            et    = 1'($urandom_range(0, 1));
            etgt  = 32'h1000 + 32'($urandom_range(0, 7) * 16);
            efall = $urandom;
            rv    = ($urandom_range(0, 99) < 60);
            ordy  = ($urandom_range(0, 99) < 50);
            if (mq.size() > 0 && $urandom_range(0, 99) < 85) begin
                k    = $urandom_range(0, mq.size() - 1);
                rtag = 3'((m_head + k) % DEPTH);
                rtk  = ($urandom_range(0, 99) < 80) ? mq[k].pt : ~mq[k].pt;
                rtgt = (rtk && $urandom_range(0, 99) < 85) ? mq[k].ptgt
                                                           : 32'h1000 + 32'($urandom_range(0, 7) * 16);
            end else begin
                rtag = 3'($urandom_range(0, 7));
                rtk  = 1'($urandom_range(0, 1));
                rtgt = $urandom;
            end
            applyStimulus(r, ev, et, etgt, efall, rv, rtag, rtk, rtgt, ordy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
